mem_bus_master: RTL and testbench
=================================

# mem_bus_master

Initiator-side controller for the shared single-port RAM bus: `read`, `write`, 9-bit `addr`, bidirectional 32-bit `data`. It accepts one word request at a time from the CPU datapath over a valid/ready handshake and sequences the RAM strobes with explicit setup, access and hold phases. It owns the bus tristate and returns read data or an error on a one-cycle response pulse. It sits between the CPU's memory stage (MAR/MDR side) and the RAM.

## Interface
Parameters:
- `ADDR_W`, 9, width of request and bus address
- `DATA_W`, 32, word width
- `MEM_DEPTH`, 256, number of implemented RAM words; addresses >= this are rejected
- `WAIT_CYCLES`, 1, cycles the strobe is held asserted (legal range 1..15)

Ports:
- `clock` in 1: sole clock; all state changes on the rising edge
- `clear` in 1: synchronous, active-high reset
- `req_valid` in 1: request present
- `req_write` in 1: 1 = write, 0 = read
- `req_addr` in ADDR_W: word address
- `req_wdata` in DATA_W: write data
- `req_ready` out 1: controller can accept a request this cycle
- `rsp_valid` out 1: one-cycle pulse; the response fields are valid
- `rsp_rdata` out DATA_W: read data; 0 for writes and errors
- `rsp_err` out 1: address out of range; no bus access was made
- `read` out 1: RAM read strobe
- `write` out 1: RAM write strobe
- `addr` out ADDR_W: RAM address
- `data` inout DATA_W: RAM data bus; driven only during write transactions

## Operation
- **Handshake:** acceptance occurs on an edge where `req_valid && req_ready`. At acceptance, `req_write`, `req_addr` and `req_wdata` are latched. The request inputs are ignored at all other times.
- **FSM states:** IDLE, SETUP, ACCESS, HOLD, RESP.
  - IDLE: `req_ready`=1. On acceptance, go to SETUP if `req_addr` < MEM_DEPTH; otherwise go to RESP with the error flag set.
  - SETUP (1 cycle): `addr` = latched address. Both strobes are 0. For a write, `data` is driven with the latched write data.
  - ACCESS (WAIT_CYCLES cycles, tracked by a down-counter): `read` or `write` = 1. On a read, `data` is sampled into the response register on the edge that leaves ACCESS.
  - HOLD (1 cycle): both strobes are 0 and `addr` is unchanged. For a write, `data` is still driven; this is the hold time. For a read, the bus is undriven (turnaround).
  - RESP (1 cycle): `rsp_valid`=1, and `rsp_rdata`/`rsp_err` are valid. Next state is IDLE.
- `req_ready` is 1 only in IDLE. No request is accepted in RESP.
- `data` is high-impedance in every state except SETUP, ACCESS and HOLD of a write.
- `read` and `write` are never 1 in the same cycle. The bench checks this every cycle.
- All bus outputs (`read`, `write`, `addr`, data drive enable, data out) are registered, so there are no combinational paths from the request inputs to the bus.
- `addr` holds its last value in IDLE and RESP; it is not returned to 0.
- `rsp_rdata` and `rsp_err` hold their values after RESP until the next RESP.
- **Error path:** an out-of-range request produces no strobe, `addr` unchanged, `rsp_err`=1, `rsp_rdata`=0.

## Timing
- **Reset:** `clear` takes effect at the edge where it is sampled, from any state. After that edge:
  - state = IDLE, `req_ready`=1;
  - `read`=0, `write`=0, `addr`=0, `data`=Z;
  - `rsp_valid`=0, `rsp_rdata`=0, `rsp_err`=0.
- **Reset mid-transaction:** the strobe drops and the bus is released at the reset edge. No response is issued, and the in-flight request is discarded.
- **Latency, acceptance edge T0:**
  - SETUP in T0→T1.
  - ACCESS for WAIT_CYCLES cycles.
  - HOLD for 1 cycle.
  - `rsp_valid` high in cycle 3+WAIT_CYCLES after T0.
  - `req_ready` returns 1 one cycle later.
- **Throughput:** one transaction per 4+WAIT_CYCLES cycles.
- **Error latency:** `rsp_valid` in the cycle immediately after T0; `req_ready` returns 1 one cycle after that.
- **Read capture:** RAM data must be stable by the last ACCESS edge, i.e. a WAIT_CYCLES-cycle access window after a 1-cycle address setup.
- **Write data window:** data is valid for 1 cycle before the `write` rise and 1 cycle after the `write` fall.
- **Back-to-back requests:** `req_valid` held high across RESP is accepted on the first IDLE cycle, and the next SETUP follows immediately.

## Test plan
- Reset, then a write of 0xDEADBEEF to address 85 (WAIT_CYCLES=1):
  - `write` high for exactly 1 cycle;
  - `data`=0xDEADBEEF from SETUP through HOLD;
  - `rsp_valid` 4 cycles after acceptance, with `rsp_err`=0 and `rsp_rdata`=0.
- Read of address 85 from a RAM model preloaded with 0x00000002:
  - `read` high 1 cycle;
  - `data` never driven by the DUT;
  - `rsp_rdata`=0x00000002 when `rsp_valid`=1.
- Read of address 256 and write of address 511:
  - no `read`/`write` pulse and `addr` unchanged;
  - `rsp_valid` 1 cycle after acceptance, `rsp_err`=1, `rsp_rdata`=0.
- Back-to-back: write 0x12345678 to address 0, `req_valid` held, then read address 0:
  - second acceptance on the first IDLE cycle;
  - read returns 0x12345678;
  - `read`/`write` never both high.
- Reset during ACCESS of a write with WAIT_CYCLES=3:
  - `write`=0 and `data`=Z after the reset edge;
  - no `rsp_valid`;
  - `req_ready`=1 the next cycle, and the following request completes normally.
- WAIT_CYCLES=3 read:
  - `read` high exactly 3 cycles;
  - `rsp_valid` exactly 6 cycles after acceptance.

Source files
------------

// File: rtl/mem_bus_if.sv
// Request/response handshake and RAM strobe/address signals of the memory bus master.
// The bidirectional data bus stays a plain inout port on the master.
interface mem_bus_if #(
  parameter int unsigned ADDR_W = 9,
  parameter int unsigned DATA_W = 32
) ();
  logic              req_valid;
  logic              req_write;
  logic [ADDR_W-1:0] req_addr;
  logic [DATA_W-1:0] req_wdata;
  logic              req_ready;
  logic              rsp_valid;
  logic [DATA_W-1:0] rsp_rdata;
  logic              rsp_err;
  logic              read;
  logic              write;
  logic [ADDR_W-1:0] addr;

  modport master (
    input  req_valid, req_write, req_addr, req_wdata,
    output req_ready, rsp_valid, rsp_rdata, rsp_err, read, write, addr
  );

  modport slave (
    output req_valid, req_write, req_addr, req_wdata,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err, read, write, addr
  );
endinterface

// File: rtl/mem_bus_master.sv
// Single-word RAM bus initiator: setup / access / hold strobe sequencing with a
// one-cycle response pulse. All bus-facing outputs come straight from flops.
module mem_bus_master #(
  parameter int unsigned ADDR_W      = 9,
  parameter int unsigned DATA_W      = 32,
  parameter int unsigned MEM_DEPTH   = 256,
  parameter int unsigned WAIT_CYCLES = 1
) (
  input  logic              clock,
  input  logic              clear,
  mem_bus_if.master         bus,
  inout  wire  [DATA_W-1:0] data
);

  localparam logic [ADDR_W:0] DepthLim  = (ADDR_W + 1)'(MEM_DEPTH);
  localparam logic [3:0]      WaitLoad  = 4'(WAIT_CYCLES - 1);

  typedef enum logic [2:0] {StIdle, StSetup, StAccess, StHold, StResp} state_e;

  state_e            state_q;
  logic [3:0]        cnt_q;
  logic              wr_q;
  logic              ready_q;
  logic              read_q;
  logic              write_q;
  logic [ADDR_W-1:0] addr_q;
  logic              den_q;
  logic [DATA_W-1:0] dout_q;
  logic [DATA_W-1:0] cap_q;
  logic              rsp_valid_q;
  logic [DATA_W-1:0] rsp_rdata_q;
  logic              rsp_err_q;

  always_ff @(posedge clock) begin
    if (clear) begin
      state_q     <= StIdle;
      cnt_q       <= '0;
      wr_q        <= 1'b0;
      ready_q     <= 1'b1;
      read_q      <= 1'b0;
      write_q     <= 1'b0;
      addr_q      <= '0;
      den_q       <= 1'b0;
      dout_q      <= '0;
      cap_q       <= '0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
      rsp_err_q   <= 1'b0;
    end else begin
      rsp_valid_q <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (bus.req_valid) begin
            ready_q <= 1'b0;
            wr_q    <= bus.req_write;
            if ({1'b0, bus.req_addr} < DepthLim) begin
              state_q <= StSetup;
              addr_q  <= bus.req_addr;
              den_q   <= bus.req_write;
              dout_q  <= bus.req_wdata;
            end else begin
              // Rejected: straight to the response, bus untouched.
              state_q     <= StResp;
              rsp_valid_q <= 1'b1;
              rsp_err_q   <= 1'b1;
              rsp_rdata_q <= '0;
            end
          end
        end
        StSetup: begin
          state_q <= StAccess;
          cnt_q   <= WaitLoad;
          read_q  <= ~wr_q;
          write_q <= wr_q;
        end
        StAccess: begin
          if (cnt_q == 4'd0) begin
            state_q <= StHold;
            read_q  <= 1'b0;
            write_q <= 1'b0;
            // Staged so the visible response holds until the next pulse.
            if (!wr_q) cap_q <= data;
          end else begin
            cnt_q <= cnt_q - 4'd1;
          end
        end
        StHold: begin
          state_q     <= StResp;
          den_q       <= 1'b0;
          rsp_valid_q <= 1'b1;
          rsp_err_q   <= 1'b0;
          rsp_rdata_q <= wr_q ? '0 : cap_q;
        end
        StResp: begin
          state_q <= StIdle;
          ready_q <= 1'b1;
        end
        default: begin
          state_q <= StIdle;
          ready_q <= 1'b1;
        end
      endcase
    end
  end

  assign data          = den_q ? dout_q : 'z;
  assign bus.req_ready = ready_q;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_rdata = rsp_rdata_q;
  assign bus.rsp_err   = rsp_err_q;
  assign bus.read      = read_q;
  assign bus.write     = write_q;
  assign bus.addr      = addr_q;

endmodule

// File: tb/tb_mem_bus_master.sv
// Bench for mem_bus_master: two instances (WAIT_CYCLES 1 and 3), each with a RAM model
// and a bus probe that drives a known value whenever the master must leave the bus floating.
module tb_mem_bus_master;
  localparam int unsigned AW = 9;
  localparam int unsigned DW = 32;

  logic clock = 1'b0;
  logic clear;
  always #5 clock = ~clock;

  logic [1:0]    valid, wr, rdy, rsp_v, rd_s, wr_s, rsp_e, tdrive;
  logic [AW-1:0] a    [2];
  logic [AW-1:0] ad_o [2];
  logic [AW-1:0] ea   [2];
  logic [DW-1:0] wd   [2];
  logic [DW-1:0] rdat [2];
  logic [DW-1:0] probe[2];
  logic [DW-1:0] bus_v[2];
  logic [DW-1:0] er_rd[2];
  logic [1:0]    er_err;
  logic [DW-1:0] ram     [2][512];
  logic [DW-1:0] ref_mem [2][512];
  bit            init_done;
  wire  [DW-1:0] data0, data1;

  int n_tests = 0;
  int n_fail  = 0;

  mem_bus_if #(.ADDR_W(AW), .DATA_W(DW)) if0 ();
  mem_bus_if #(.ADDR_W(AW), .DATA_W(DW)) if1 ();

  mem_bus_master #(.ADDR_W(AW), .DATA_W(DW), .MEM_DEPTH(256), .WAIT_CYCLES(1)) dut0 (
    .clock (clock),
    .clear (clear),
    .bus   (if0),
    .data  (data0)
  );

  mem_bus_master #(.ADDR_W(AW), .DATA_W(DW), .MEM_DEPTH(256), .WAIT_CYCLES(3)) dut1 (
    .clock (clock),
    .clear (clear),
    .bus   (if1),
    .data  (data1)
  );

  assign if0.req_valid = valid[0];
  assign if0.req_write = wr[0];
  assign if0.req_addr  = a[0];
  assign if0.req_wdata = wd[0];
  assign if1.req_valid = valid[1];
  assign if1.req_write = wr[1];
  assign if1.req_addr  = a[1];
  assign if1.req_wdata = wd[1];
  assign rdy   = {if1.req_ready, if0.req_ready};
  assign rsp_v = {if1.rsp_valid, if0.rsp_valid};
  assign rsp_e = {if1.rsp_err,   if0.rsp_err};
  assign rd_s  = {if1.read,      if0.read};
  assign wr_s  = {if1.write,     if0.write};
  assign ad_o[0] = if0.addr;
  assign ad_o[1] = if1.addr;
  assign rdat[0] = if0.rsp_rdata;
  assign rdat[1] = if1.rsp_rdata;

  // RAM answers while its read strobe is up; otherwise the probe owns the bus unless a write phase.
  assign data0 = (rd_s[0] || tdrive[0]) ? (rd_s[0] ? ram[0][ad_o[0]] : probe[0]) : 'z;
  assign data1 = (rd_s[1] || tdrive[1]) ? (rd_s[1] ? ram[1][ad_o[1]] : probe[1]) : 'z;
  assign bus_v[0] = data0;
  assign bus_v[1] = data1;

  always @(posedge clock) begin
    if (!init_done) begin
      for (int d = 0; d < 2; d++)
        for (int i = 0; i < 512; i++) ram[d][i] <= ref_mem[d][i];
      init_done <= 1'b1;
    end else begin
      for (int d = 0; d < 2; d++)
        if (wr_s[d]) ram[d][ad_o[d]] <= bus_v[d];
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic string tg(input int d, input string s);
    return $sformatf("d%0d_%s", d, s);
  endfunction

  // Every sample point goes through here, so strobe exclusivity is checked each cycle.
  task automatic tick();
    @(negedge clock);
    for (int d = 0; d < 2; d++) check(tg(d, "excl"), 32'(rd_s[d] & wr_s[d]), 32'd0);
  endtask

  task automatic run_txn(input int d, input bit w, input logic [AW-1:0] ad,
                         input logic [DW-1:0] wdv, input bit keep);
    int wc, n, len;
    bit err, acc, ph_w;
    logic [DW-1:0] exp_rd, exp_dat;
    wc     = (d == 0) ? 1 : 3;
    err    = (ad >= 9'd256);
    len    = err ? 1 : 3 + wc;
    exp_rd = (err || w) ? '0 : ref_mem[d][ad];
    valid[d] = 1'b1;
    wr[d]    = w;
    a[d]     = ad;
    wd[d]    = wdv;
    n = 0;
    while (!rdy[d] && n < 20) begin
      tick();
      n++;
    end
    check(tg(d, "accept_wait"), 32'(n), 32'd0);
    if (!rdy[d]) begin
      valid[d] = 1'b0;
      return;
    end
    @(posedge clock);
    for (int k = 1; k <= len; k++) begin
      if (k > 1) @(posedge clock);
      #1;
      if (k == 1) begin
        if (!keep) valid[d] = 1'b0;
        wr[d] = 1'($urandom);
        a[d]  = AW'($urandom);
        wd[d] = $urandom;
      end
      ph_w      = w && !err && (k <= 2 + wc);
      acc       = !err && (k >= 2) && (k <= 1 + wc);
      tdrive[d] = !ph_w;
      tick();
      exp_dat = ph_w ? wdv : ((acc && !w) ? ref_mem[d][ad] : probe[d]);
      check(tg(d, "ready_busy"), 32'(rdy[d]), 32'd0);
      check(tg(d, "rsp_valid"), 32'(rsp_v[d]), 32'(k == len));
      check(tg(d, "read"), 32'(rd_s[d]), 32'(acc && !w));
      check(tg(d, "write"), 32'(wr_s[d]), 32'(acc && w));
      check(tg(d, "addr"), 32'(ad_o[d]), 32'(err ? ea[d] : ad));
      check(tg(d, "data"), bus_v[d], exp_dat);
      if (k == len) begin
        check(tg(d, "rsp_err"), 32'(rsp_e[d]), 32'(err));
        check(tg(d, "rsp_rdata"), rdat[d], exp_rd);
      end
    end
    if (!err) ea[d] = ad;
    if (w && !err) ref_mem[d][ad] = wdv;
    er_rd[d]  = exp_rd;
    er_err[d] = err;
    @(posedge clock);
    #1;
    tick();
    check(tg(d, "ready_back"), 32'(rdy[d]), 32'd1);
    check(tg(d, "rsp_valid_off"), 32'(rsp_v[d]), 32'd0);
    check(tg(d, "rdata_hold"), rdat[d], er_rd[d]);
    check(tg(d, "err_hold"), 32'(rsp_e[d]), 32'(er_err[d]));
    check(tg(d, "addr_hold"), 32'(ad_o[d]), 32'(ea[d]));
    check(tg(d, "data_idle"), bus_v[d], probe[d]);
  endtask

  task automatic check_reset_state();
    for (int d = 0; d < 2; d++) begin
      check(tg(d, "rst_ready"), 32'(rdy[d]), 32'd1);
      check(tg(d, "rst_read"), 32'(rd_s[d]), 32'd0);
      check(tg(d, "rst_write"), 32'(wr_s[d]), 32'd0);
      check(tg(d, "rst_addr"), 32'(ad_o[d]), 32'd0);
      check(tg(d, "rst_rsp_valid"), 32'(rsp_v[d]), 32'd0);
      check(tg(d, "rst_rdata"), rdat[d], 32'd0);
      check(tg(d, "rst_err"), 32'(rsp_e[d]), 32'd0);
      check(tg(d, "rst_data"), bus_v[d], probe[d]);
      ea[d]     = '0;
      er_rd[d]  = '0;
      er_err[d] = 1'b0;
    end
  endtask

  task automatic reset_mid(input int d, input logic [AW-1:0] ad, input logic [DW-1:0] wdv);
    valid[d] = 1'b1;
    wr[d]    = 1'b1;
    a[d]     = ad;
    wd[d]    = wdv;
    check(tg(d, "rm_ready"), 32'(rdy[d]), 32'd1);
    @(posedge clock);
    #1;
    valid[d]  = 1'b0;
    tdrive[d] = 1'b0;
    tick();
    @(posedge clock);
    #1;
    tick();
    check(tg(d, "rm_write_on"), 32'(wr_s[d]), 32'd1);
    check(tg(d, "rm_data_on"), bus_v[d], wdv);
    clear = 1'b1;
    @(posedge clock);
    #1;
    clear     = 1'b0;
    tdrive[d] = 1'b1;
    tick();
    check_reset_state();
    // The strobe was up across one edge before reset, so the RAM took the word.
    ref_mem[d][ad] = wdv;
    for (int i = 0; i < 3; i++) begin
      tick();
      check(tg(d, "rm_no_rsp"), 32'(rsp_v[d]), 32'd0);
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    clear  = 1'b1;
    valid  = '0;
    wr     = '0;
    tdrive = 2'b11;
    for (int d = 0; d < 2; d++) begin
      a[d]     = '0;
      wd[d]    = '0;
      probe[d] = $urandom | 32'h1;
      ea[d]    = '0;
      for (int i = 0; i < 512; i++) ref_mem[d][i] = $urandom;
    end
    ref_mem[0][85] = 32'h0000_0002;
    repeat (3) @(posedge clock);
    #1;
    clear = 1'b0;
    tick();
    check_reset_state();

    run_txn(0, 1'b0, 9'd85, 32'h0, 1'b0);
    run_txn(0, 1'b1, 9'd85, 32'hDEAD_BEEF, 1'b0);
    run_txn(0, 1'b0, 9'd85, 32'h0, 1'b0);
    run_txn(0, 1'b0, 9'd256, 32'h0, 1'b0);
    run_txn(0, 1'b1, 9'd511, 32'hA5A5_A5A5, 1'b0);
    run_txn(0, 1'b1, 9'd0, 32'h1234_5678, 1'b1);
    run_txn(0, 1'b0, 9'd0, 32'h0, 1'b0);

    run_txn(1, 1'b0, 9'($urandom_range(0, 255)), 32'h0, 1'b0);
    reset_mid(1, 9'd40, 32'hCAFE_F00D);
    run_txn(1, 1'b1, 9'd40, 32'h0BAD_C0DE, 1'b0);
    run_txn(1, 1'b0, 9'd40, 32'h0, 1'b0);

    for (int i = 0; i < 60; i++) begin
      int   d;
      bit   b2b;
      d   = int'($urandom_range(0, 1));
      b2b = 1'($urandom);
      run_txn(d, 1'($urandom), 9'($urandom_range(0, 300)), $urandom, b2b);
      if (b2b) run_txn(d, 1'($urandom), 9'($urandom_range(0, 300)), $urandom, 1'b0);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
